// File: rtl/ram_read_streamer.sv
`default_nettype none
// ============================================================================
// Module   : ram_read_streamer
// Purpose  : Read-side controller for a single-port RAM. Sweeps a programmed
//            address range (with modulo wrap), absorbs the fixed RAM read
//            latency with a valid shift register, and delivers the words as
//            a valid/ready stream through a credit-managed skid FIFO so that
//            downstream backpressure never drops data.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            start             - launch pulse (only honoured in IDLE)
//            base_addr         - first address of the sweep
//            num_words         - word count, 0..2^ADDR_WIDTH
//            busy, done        - sweep in progress / end-of-sweep pulse
//            ram_address       - registered RAM address
//            ram_wren          - tied low, this block only reads
//            ram_rd_data       - RAM read data
//            out_data/valid/ready/last - output stream
// Revision : 1.0 - initial release
// ============================================================================
module ram_read_streamer #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // Wide enough to hold outstanding + fifo_count without overflow.
  localparam int CW    = $clog2(FIFO_DEPTH + RAM_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t                 state, state_next;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [ADDR_WIDTH:0]    remaining_issue;
  logic                   empty_sweep;
  logic [RAM_LATENCY-1:0] pipe_valid;
  logic [RAM_LATENCY-1:0] pipe_last;

  logic [DATA_WIDTH-1:0]  fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  fifo_last;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]          fifo_count;
  logic [CW-1:0]          outstanding;

  logic issue, last_issue, fifo_wr, fifo_rd, last_fire;

  assign ram_wren = 1'b0;

  // Reads currently travelling through the RAM latency pipeline.
  always_comb begin
    outstanding = '0;
    for (int i = 0; i < RAM_LATENCY; i++) begin
      outstanding = outstanding + CW'(pipe_valid[i]);
    end
  end

  // Credit check: every issued read already owns a FIFO slot, so the FIFO
  // can never be full when the pipeline tail delivers a word.
  assign issue      = (state == ISSUE) && ((outstanding + fifo_count) < CW'(FIFO_DEPTH));
  assign last_issue = (remaining_issue == (ADDR_WIDTH + 1)'(1));
  assign fifo_wr    = pipe_valid[RAM_LATENCY-1];

  assign out_valid  = (fifo_count != '0);
  assign out_data   = fifo_data[rd_ptr];
  assign out_last   = out_valid && fifo_last[rd_ptr];
  assign fifo_rd    = out_valid && out_ready;
  assign last_fire  = fifo_rd && fifo_last[rd_ptr];

  // Next-state logic. A zero-length sweep passes through DRAIN (which exits
  // at once) so that done appears two cycles after start, the same
  // registered-done path used by non-empty sweeps.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = ISSUE;
      ISSUE: if (issue && last_issue) state_next = DRAIN;
      DRAIN: if (last_fire || empty_sweep) state_next = FIN;
      FIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (state == IDLE && start && num_words == '0) begin
      state_next = DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      ram_address     <= '0;
      addr            <= '0;
      remaining_issue <= '0;
      empty_sweep     <= 1'b0;
      pipe_valid      <= '0;
      pipe_last       <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_count      <= '0;
    end else begin
      state <= state_next;
      // DRAIN entered straight from IDLE is the zero-length case: not busy.
      busy  <= (state_next == ISSUE) || (state_next == DRAIN && state != IDLE);
      done  <= (state_next == FIN);

      if (state == IDLE && start) begin
        addr            <= base_addr;
        remaining_issue <= num_words;
        empty_sweep     <= (num_words == '0);
      end else if (issue) begin
        ram_address     <= addr;
        addr            <= addr + 1'b1;
        remaining_issue <= remaining_issue - 1'b1;
      end

      pipe_valid <= (pipe_valid << 1) | RAM_LATENCY'(issue);
      pipe_last  <= (pipe_last << 1) | RAM_LATENCY'(issue && last_issue);

      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_data[wr_ptr] <= ram_rd_data;
      fifo_last[wr_ptr] <= pipe_last[RAM_LATENCY-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_read_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_read_streamer
// Purpose  : Scoreboard bench for ram_read_streamer with a registered-output
//            RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_read_streamer;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic          busy, done;
  logic [AW-1:0] ram_address;
  logic          ram_wren;
  logic [DW-1:0] ram_rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  ram_read_streamer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_rd_data(ram_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  // RAM model: address is registered inside the DUT, output registered here.
  logic [DW-1:0] mem [4096];
  always @(posedge clk) ram_rd_data <= mem[ram_address];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;
  exp_t exp_q[$];

  task automatic push(input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    exp_q.push_back(e);
  endtask

  // Ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = held low.
  int ready_mode = 0;
  int ph = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (ph == 0 || ph == 3);
          ph = (ph + 1) % 4;
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  int            hs_count   = 0;
  int            done_count = 0;
  int            valid_cnt  = 0;
  int            hs_cyc[$];
  logic [AW-1:0] addr_log[$];
  logic [AW-1:0] last_addr  = '0;
  logic          hold_v     = 1'b0;
  logic [DW-1:0] held_d;
  logic          held_l;

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      check("ram_wren", ram_wren, 0);
      if (hold_v) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held_d);
        check("stall_last", out_last, held_l);
      end
      if (out_valid) valid_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_word: got %0h expected no word", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_last", out_last, e.l);
        end
        hs_count++;
        hs_cyc.push_back(cyc);
      end
      hold_v = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
      if (done) done_count++;
      if (ram_address !== last_addr) begin
        addr_log.push_back(ram_address);
        last_addr = ram_address;
      end
    end
  end

  int start_cyc;

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = b;
    num_words = n;
    start_cyc = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int dcyc);
    bit seen = 1'b0;
    dcyc = -1;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        dcyc = cyc;
      end
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: got no done within %0d cycles", limit);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation timeout expected completion");
    $fatal(1);
  end

  initial begin
    int dcyc, dc0, hs0, v0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_addr", ram_address, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic 4-word sweep at full throughput.
    for (int i = 0; i < 4; i++) mem[i] = 32'h10 + i;
    push(32'h10, 0); push(32'h11, 0); push(32'h12, 0); push(32'h13, 1);
    hs_cyc.delete();
    do_start(12'h000, 13'd4);
    wait_done(50, dcyc);
    check("t1_done_latency", dcyc - start_cyc, 8);
    check("t1_first_word_cycle", hs_cyc[0] - start_cyc, 4);
    check("t1_consecutive", hs_cyc[3] - hs_cyc[0], 3);
    idle(4);
    check("t1_queue_empty", exp_q.size(), 0);

    // Same sweep under 1,0,0,1 backpressure.
    ph = 0;
    ready_mode = 1;
    push(32'h10, 0); push(32'h11, 0); push(32'h12, 0); push(32'h13, 1);
    do_start(12'h000, 13'd4);
    wait_done(100, dcyc);
    idle(4);
    check("t2_queue_empty", exp_q.size(), 0);
    ready_mode = 0;
    idle(2);

    // Address wrap at the top of the RAM.
    mem[12'hFFE] = 32'hDEADBEEF; mem[12'hFFF] = 32'hA;
    mem[12'h000] = 32'hB;        mem[12'h001] = 32'hC;
    push(32'hDEADBEEF, 0); push(32'hA, 0); push(32'hB, 0); push(32'hC, 1);
    addr_log.delete();
    do_start(12'hFFE, 13'd4);
    wait_done(50, dcyc);
    idle(3);
    check("t3_addr_count", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      check("t3_addr0", addr_log[0], 12'hFFE);
      check("t3_addr1", addr_log[1], 12'hFFF);
      check("t3_addr2", addr_log[2], 12'h000);
      check("t3_addr3", addr_log[3], 12'h001);
    end
    check("t3_queue_empty", exp_q.size(), 0);

    // Zero-length sweep.
    v0 = valid_cnt;
    do_start(12'h123, 13'd0);
    wait_done(20, dcyc);
    check("t4_zero_done_latency", dcyc - start_cyc, 2);
    idle(4);
    check("t4_zero_no_valid", valid_cnt - v0, 0);

    // Full 4096-word sweep from address 5.
    for (int i = 0; i < 4096; i++) mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0001);
    for (int k = 0; k < 4096; k++) begin
      int a;
      a = (5 + k) % 4096;
      push(32'h5A00_0000 ^ (a * 32'h0001_0001), (k == 4095));
    end
    do_start(12'h005, 13'd4096);
    wait_done(5000, dcyc);
    check("t4_full_done_latency", dcyc - start_cyc, 4096 + 4);
    check("t4_full_final_addr", ram_address, 12'h004);
    idle(3);
    check("t4_full_queue_empty", exp_q.size(), 0);

    // Start while busy is ignored.
    for (int i = 0; i < 4; i++) mem[12'h010 + i] = 32'hCAFE_0000 + i;
    for (int i = 0; i < 4; i++) mem[12'h080 + i] = 32'hBAD0_0000 + i;
    push(32'hCAFE_0000, 0); push(32'hCAFE_0001, 0);
    push(32'hCAFE_0002, 0); push(32'hCAFE_0003, 1);
    dc0 = done_count;
    do_start(12'h010, 13'd4);
    do_start(12'h080, 13'd3);
    wait_done(50, dcyc);
    idle(10);
    check("t5_done_once", done_count - dc0, 1);
    check("t5_queue_empty", exp_q.size(), 0);

    // Reset mid-sweep after two words, then a fresh 2-word sweep.
    for (int i = 0; i < 4; i++) mem[12'h020 + i] = 32'h2020_0000 + i;
    push(32'h2020_0000, 0); push(32'h2020_0001, 0);
    push(32'h2020_0002, 0); push(32'h2020_0003, 1);
    hs0 = hs_count;
    dc0 = done_count;
    do_start(12'h020, 13'd4);
    for (int i = 0; i < 50 && hs_count < hs0 + 2; i++) begin
      @(negedge clk); #1;
    end
    check("t6_two_delivered", hs_count - hs0, 2);
    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    idle(6);
    check("t6_no_done", done_count - dc0, 0);
    ready_mode = 0;
    mem[12'h030] = 32'h3030_AAAA; mem[12'h031] = 32'h3030_BBBB;
    push(32'h3030_AAAA, 0); push(32'h3030_BBBB, 1);
    hs0 = hs_count;
    do_start(12'h030, 13'd2);
    wait_done(50, dcyc);
    idle(6);
    check("t6_fresh_words", hs_count - hs0, 2);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
